atm_keypad_entry: RTL

- Upstream front-end of the ATM controller: turns raw keypad keystrokes into the controller's PIN interface (digito/add_digit/digito_stb) and amount interface (monto/monto_stb).
- Tracks a PIN phase, then an amount phase; accumulates decimal amount digits into a binary value with saturation.
- Aborts to idle on inactivity timeout or cancel key.

---
 rtl/atm_keypad_pkg.sv | 24 ++
 rtl/atm_bcd_acumulador.sv | 31 +++
 rtl/atm_keypad_entry.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/atm_keypad_pkg.sv
// Shared constants for the ATM keypad front-end.
//   - Key codes delivered on the keypad tecla bus.
//   - Entry-FSM state encoding (kept as plain localparams for legacy tools).
//   - Default amount saturation limit.
package atm_keypad_pkg;

  // Key codes: 0-9 are decimal digits, 0xD-0xF are unused and rejected.
  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  // Entry FSM states.
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StPin    = 2'd1;
  localparam logic [1:0] StAmount = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [31:0] MAX_MONTO_DEFAULT = 32'd999999;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_bcd_acumulador.sv
// Decimal-entry accumulator step: acc_next = min(acc * 10 + digit, MAX_MONTO).
// Purely combinational.
// Ports:
//   acc      in   MONTO_W  current binary amount (never above MAX_MONTO)
//   digit    in   4        decimal digit 0-9 being appended
//   acc_next out  MONTO_W  updated amount, clamped to MAX_MONTO
//   sat      out  1        high when the clamp was applied
module atm_bcd_acumulador
  import atm_keypad_pkg::*;
#(
  parameter int unsigned          MONTO_W   = 32,
  parameter logic [MONTO_W-1:0]   MAX_MONTO = MONTO_W'(MAX_MONTO_DEFAULT)
) (
  input  logic [MONTO_W-1:0] acc,
  input  logic [3:0]         digit,
  output logic [MONTO_W-1:0] acc_next,
  output logic               sat
);

  // Four extra bits hold acc*10+9 for any MONTO_W-bit acc without overflow.
  localparam int unsigned WideW = MONTO_W + 4;

  logic [WideW-1:0] wide;

  always_comb begin
    wide     = ({4'b0000, acc} * WideW'(10)) + WideW'(digit);
    sat      = wide > {4'b0000, MAX_MONTO};
    acc_next = sat ? MAX_MONTO : wide[MONTO_W-1:0];
  end

endmodule

// File: rtl/atm_keypad_entry.sv
// ATM keypad front-end: turns raw keystrokes into the controller's PIN
// interface (digito/add_digit/digito_stb) and amount interface
// (monto/monto_stb). PIN phase, then amount phase, with inactivity timeout
// and cancel. All outputs are registered (one cycle after the causing edge).
// Ports:
//   clk              in   1        clock, rising edge
//   rst              in   1        asynchronous active-low reset
//   tarjeta_recibida in   1        card present; sampled only in IDLE/DONE
//   tecla_stb        in   1        tecla valid strobe
//   tecla            in   4        key code
//   digito           out  4        last accepted PIN digit
//   add_digit        out  1        pulse per accepted PIN digit
//   digito_stb       out  1        pulse: PIN complete
//   monto            out  MONTO_W  confirmed amount, held until next card
//   monto_stb        out  1        pulse: amount confirmed
//   cuenta_pin       out  3        PIN digits accepted so far
//   tecla_error      out  1        pulse on rejected key
//   timeout          out  1        pulse on inactivity abort
module atm_keypad_entry
  import atm_keypad_pkg::*;
#(
  parameter int unsigned        MONTO_W     = 32,
  parameter logic [MONTO_W-1:0] MAX_MONTO   = MONTO_W'(MAX_MONTO_DEFAULT),
  parameter int unsigned        PIN_DIGITS  = 4,
  parameter int unsigned        TIMEOUT_CYC = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tarjeta_recibida,
  input  logic               tecla_stb,
  input  logic [3:0]         tecla,
  output logic [3:0]         digito,
  output logic               add_digit,
  output logic               digito_stb,
  output logic [MONTO_W-1:0] monto,
  output logic               monto_stb,
  output logic [2:0]         cuenta_pin,
  output logic               tecla_error,
  output logic               timeout
);

  localparam int unsigned       TimerW    = $clog2(TIMEOUT_CYC + 1);
  // Timer holds the number of idle cycles already seen; the edge that would
  // make it TIMEOUT_CYC is the one that aborts.
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]        PinFull   = 3'(PIN_DIGITS);

  logic [1:0]         state_q, state_d;
  logic [2:0]         cuenta_q, cuenta_d;
  logic [MONTO_W-1:0] acc_q, acc_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [3:0]         digito_q, digito_d;
  logic [MONTO_W-1:0] monto_q, monto_d;
  logic               add_digit_q, add_digit_d;
  logic               digito_stb_q, digito_stb_d;
  logic               monto_stb_q, monto_stb_d;
  logic               tecla_error_q, tecla_error_d;
  logic               timeout_q, timeout_d;

  logic [MONTO_W-1:0] acc_step;
  logic               acc_sat;

  atm_bcd_acumulador #(
    .MONTO_W   (MONTO_W),
    .MAX_MONTO (MAX_MONTO)
  ) u_acumulador (
    .acc      (acc_q),
    .digit    (tecla),
    .acc_next (acc_step),
    .sat      (acc_sat)
  );

  always_comb begin
    state_d       = state_q;
    cuenta_d      = cuenta_q;
    acc_d         = acc_q;
    timer_d       = timer_q;
    digito_d      = digito_q;
    monto_d       = monto_q;
    add_digit_d   = 1'b0;
    digito_stb_d  = 1'b0;
    monto_stb_d   = 1'b0;
    tecla_error_d = 1'b0;
    timeout_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (tarjeta_recibida) begin
          state_d  = StPin;
          cuenta_d = '0;
          acc_d    = '0;
          monto_d  = '0;
          timer_d  = '0;
        end
      end

      StDone: begin
        if (!tarjeta_recibida) begin
          state_d = StIdle;
        end
      end

      StPin, StAmount: begin
        if (tecla_stb) begin
          // Any key restarts the idle timer, even one arriving on the expiry cycle.
          timer_d = '0;
          if (tecla == KEY_CANCEL) begin
            state_d  = StIdle;
            cuenta_d = '0;
            acc_d    = '0;
          end else if (tecla > KEY_CANCEL) begin
            tecla_error_d = 1'b1;
          end else if (state_q == StPin) begin
            if (is_digit(tecla)) begin
              if (cuenta_q < PinFull) begin
                digito_d    = tecla;
                add_digit_d = 1'b1;
                cuenta_d    = cuenta_q + 3'd1;
              end else begin
                tecla_error_d = 1'b1;
              end
            end else if (tecla == KEY_ENTER) begin
              if (cuenta_q == PinFull) begin
                digito_stb_d = 1'b1;
                state_d      = StAmount;
              end else begin
                tecla_error_d = 1'b1;
              end
            end else begin
              // CLEAR: downstream overwrites its own shift register on re-entry.
              cuenta_d = '0;
            end
          end else begin
            if (is_digit(tecla)) begin
              acc_d         = acc_step;
              tecla_error_d = acc_sat;
            end else if (tecla == KEY_ENTER) begin
              if (acc_q == '0) begin
                tecla_error_d = 1'b1;
              end else begin
                monto_d     = acc_q;
                monto_stb_d = 1'b1;
                state_d     = StDone;
              end
            end else begin
              acc_d = '0;
            end
          end
        end else if (timer_q == TimerLast) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
          cuenta_d  = '0;
          acc_d     = '0;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cuenta_q      <= '0;
      acc_q         <= '0;
      timer_q       <= '0;
      digito_q      <= '0;
      monto_q       <= '0;
      add_digit_q   <= 1'b0;
      digito_stb_q  <= 1'b0;
      monto_stb_q   <= 1'b0;
      tecla_error_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cuenta_q      <= cuenta_d;
      acc_q         <= acc_d;
      timer_q       <= timer_d;
      digito_q      <= digito_d;
      monto_q       <= monto_d;
      add_digit_q   <= add_digit_d;
      digito_stb_q  <= digito_stb_d;
      monto_stb_q   <= monto_stb_d;
      tecla_error_q <= tecla_error_d;
      timeout_q     <= timeout_d;
    end
  end

  assign digito      = digito_q;
  assign add_digit   = add_digit_q;
  assign digito_stb  = digito_stb_q;
  assign monto       = monto_q;
  assign monto_stb   = monto_stb_q;
  assign cuenta_pin  = cuenta_q;
  assign tecla_error = tecla_error_q;
  assign timeout     = timeout_q;

endmodule
